mipi_rx_raw10_line_ctrl: RTL and testbench

Sequencer between the CSI-2 packet decoder and `mipi_rx_raw10_depacker`. It tracks frame and line state from packet headers, lets through exactly the RAW10 long-packet payload beats for each line, and drives the depacker's contiguous valid window, including one trailing flush beat. It also provides frame/line timing strobes, a line counter and sticky error flags for downstream ISP logic.

---
 rtl/mipi_rx_raw10_line_ctrl.sv | 165 ++++++++++++++++
 tb/tb_mipi_rx_raw10_line_ctrl.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mipi_rx_raw10_line_ctrl.sv
// Frame/line sequencer between the CSI-2 packet decoder and the RAW10 depacker.
// Gates RAW10 payload beats into a contiguous valid window and appends one zero flush beat per line.
module mipi_rx_raw10_line_ctrl #(
    parameter logic [5:0] RAW10_DT = 6'h2B,
    parameter logic [5:0] FS_DT    = 6'h00,
    parameter logic [5:0] FE_DT    = 6'h01
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        pkt_hdr_valid_i,
    input  logic [5:0]  pkt_dt_i,
    input  logic [15:0] pkt_wc_i,
    input  logic        payload_valid_i,
    input  logic [31:0] payload_i,
    output logic        depack_valid_o,
    output logic [31:0] depack_data_o,
    output logic        frame_active_o,
    output logic        line_active_o,
    output logic        frame_start_o,
    output logic        frame_end_o,
    output logic        line_done_o,
    output logic [15:0] line_count_o,
    input  logic        clear_err_i,
    output logic        err_wc_o,
    output logic        err_gap_o,
    output logic        err_trunc_o
);

    localparam int unsigned WC_W       = 16;
    localparam int unsigned DT_W       = 6;
    localparam int unsigned BEAT_BYTES = 4;
    localparam int unsigned PIX_GROUP  = 5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FRAME,
        ST_LINE,
        ST_FLUSH
    } state_t;

    state_t            state_q;
    logic [WC_W-1:0]   bytes_left_q;
    logic              skid_valid_q;
    logic [DT_W-1:0]   skid_dt_q;
    logic [WC_W-1:0]   skid_wc_q;

    logic              hdr_v_c;
    logic [DT_W-1:0]   hdr_dt_c;
    logic [WC_W-1:0]   hdr_wc_c;
    logic              hdr_fs_c;
    logic              hdr_fe_c;
    logic              hdr_line_c;
    logic              hdr_wc_bad_c;

    // A header parked during the flush beat takes precedence over the live port.
    always_comb begin
        hdr_v_c      = skid_valid_q | pkt_hdr_valid_i;
        hdr_dt_c     = skid_valid_q ? skid_dt_q : pkt_dt_i;
        hdr_wc_c     = skid_valid_q ? skid_wc_q : pkt_wc_i;
        hdr_fs_c     = hdr_v_c && (hdr_dt_c == FS_DT);
        hdr_fe_c     = hdr_v_c && (hdr_dt_c == FE_DT);
        hdr_line_c   = hdr_v_c && (hdr_dt_c == RAW10_DT) && (hdr_wc_c != WC_W'(0));
        hdr_wc_bad_c = (hdr_wc_c % WC_W'(PIX_GROUP)) != WC_W'(0);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q        <= ST_IDLE;
            bytes_left_q   <= '0;
            skid_valid_q   <= 1'b0;
            skid_dt_q      <= '0;
            skid_wc_q      <= '0;
            depack_valid_o <= 1'b0;
            depack_data_o  <= '0;
            frame_active_o <= 1'b0;
            line_active_o  <= 1'b0;
            frame_start_o  <= 1'b0;
            frame_end_o    <= 1'b0;
            line_done_o    <= 1'b0;
            line_count_o   <= '0;
            err_wc_o       <= 1'b0;
            err_gap_o      <= 1'b0;
            err_trunc_o    <= 1'b0;
        end else begin
            frame_start_o  <= 1'b0;
            frame_end_o    <= 1'b0;
            line_done_o    <= 1'b0;
            depack_valid_o <= 1'b0;
            depack_data_o  <= '0;
            line_active_o  <= 1'b0;
            skid_valid_q   <= 1'b0;
            // Later set assignments in this block override the clear.
            if (clear_err_i) begin
                err_wc_o    <= 1'b0;
                err_gap_o   <= 1'b0;
                err_trunc_o <= 1'b0;
            end

            case (state_q)
                ST_IDLE: begin
                    if (hdr_fs_c) begin
                        state_q        <= ST_FRAME;
                        frame_active_o <= 1'b1;
                        frame_start_o  <= 1'b1;
                        line_count_o   <= '0;
                    end
                end

                ST_FLUSH: begin
                    depack_valid_o <= 1'b1;
                    line_active_o  <= 1'b1;
                    line_done_o    <= 1'b1;
                    line_count_o   <= line_count_o + WC_W'(1);
                    state_q        <= ST_FRAME;
                    if (pkt_hdr_valid_i) begin
                        skid_valid_q <= 1'b1;
                        skid_dt_q    <= pkt_dt_i;
                        skid_wc_q    <= pkt_wc_i;
                    end
                end

                default: begin
                    if (state_q == ST_LINE && !hdr_v_c) begin
                        if (payload_valid_i) begin
                            depack_valid_o <= 1'b1;
                            depack_data_o  <= payload_i;
                            line_active_o  <= 1'b1;
                            bytes_left_q   <= (bytes_left_q > WC_W'(BEAT_BYTES)) ?
                                              bytes_left_q - WC_W'(BEAT_BYTES) : '0;
                            if (bytes_left_q <= WC_W'(BEAT_BYTES)) begin
                                state_q <= ST_FLUSH;
                            end
                        end else begin
                            err_gap_o <= 1'b1;
                            state_q   <= ST_FRAME;
                        end
                    end else if (hdr_v_c) begin
                        // In LINE a header aborts the line and is then handled as in FRAME.
                        if (state_q == ST_LINE) begin
                            err_trunc_o <= 1'b1;
                        end
                        if (hdr_fs_c) begin
                            state_q       <= ST_FRAME;
                            frame_start_o <= 1'b1;
                            line_count_o  <= '0;
                        end else if (hdr_fe_c) begin
                            state_q        <= ST_IDLE;
                            frame_active_o <= 1'b0;
                            frame_end_o    <= 1'b1;
                        end else if (hdr_line_c) begin
                            state_q      <= ST_LINE;
                            bytes_left_q <= hdr_wc_c;
                            if (hdr_wc_bad_c) begin
                                err_wc_o <= 1'b1;
                            end
                        end else begin
                            state_q <= ST_FRAME;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mipi_rx_raw10_line_ctrl.sv
// Directed bench for mipi_rx_raw10_line_ctrl: frame/line sequencing, flush beat, errors, skid and reset.
module tb_mipi_rx_raw10_line_ctrl;

    localparam logic [5:0] DT_RAW = 6'h2B;
    localparam logic [5:0] DT_FS  = 6'h00;
    localparam logic [5:0] DT_FE  = 6'h01;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        pkt_hdr_valid_i = 1'b0;
    logic [5:0]  pkt_dt_i = '0;
    logic [15:0] pkt_wc_i = '0;
    logic        payload_valid_i = 1'b0;
    logic [31:0] payload_i = '0;
    logic        clear_err_i = 1'b0;
    logic        depack_valid_o;
    logic [31:0] depack_data_o;
    logic        frame_active_o;
    logic        line_active_o;
    logic        frame_start_o;
    logic        frame_end_o;
    logic        line_done_o;
    logic [15:0] line_count_o;
    logic        err_wc_o;
    logic        err_gap_o;
    logic        err_trunc_o;

    int checks = 0;
    int failures = 0;
    int dv_cnt = 0;
    logic [31:0] dsum = '0;
    int base_cnt;
    logic [31:0] base_sum;

    mipi_rx_raw10_line_ctrl dut (
        .clk_i           (clk_i),
        .rst_n_i         (rst_n_i),
        .pkt_hdr_valid_i (pkt_hdr_valid_i),
        .pkt_dt_i        (pkt_dt_i),
        .pkt_wc_i        (pkt_wc_i),
        .payload_valid_i (payload_valid_i),
        .payload_i       (payload_i),
        .depack_valid_o  (depack_valid_o),
        .depack_data_o   (depack_data_o),
        .frame_active_o  (frame_active_o),
        .line_active_o   (line_active_o),
        .frame_start_o   (frame_start_o),
        .frame_end_o     (frame_end_o),
        .line_done_o     (line_done_o),
        .line_count_o    (line_count_o),
        .clear_err_i     (clear_err_i),
        .err_wc_o        (err_wc_o),
        .err_gap_o       (err_gap_o),
        .err_trunc_o     (err_trunc_o)
    );

    always #5 clk_i = ~clk_i;

    // Tally of forwarded beats and their data, sampled mid-cycle.
    always @(negedge clk_i) begin
        if (depack_valid_o === 1'b1) begin
            dv_cnt = dv_cnt + 1;
            dsum   = dsum + depack_data_o;
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic send_hdr(input logic [5:0] dt, input logic [15:0] wc);
        pkt_hdr_valid_i = 1'b1;
        pkt_dt_i        = dt;
        pkt_wc_i        = wc;
        tick();
        pkt_hdr_valid_i = 1'b0;
    endtask

    // Beat i carries 0x01010101*(i+1).
    task automatic send_beats(input int n);
        for (int i = 0; i < n; i++) begin
            payload_valid_i = 1'b1;
            payload_i       = 32'h0101_0101 * 32'(i + 1);
            tick();
        end
        payload_valid_i = 1'b0;
        payload_i       = '0;
    endtask

    task automatic test_reset();
        rst_n_i = 1'b0;
        tick();
        tick();
        checks++;
        if ({depack_valid_o, depack_data_o, frame_active_o, line_active_o, frame_start_o, frame_end_o,
             line_done_o, line_count_o, err_wc_o, err_gap_o, err_trunc_o} !== 57'd0) begin
            failures++;
            $display("FAIL reset_outputs: got dv=%b data=%h cnt=%h fa=%b", depack_valid_o, depack_data_o,
                     line_count_o, frame_active_o);
        end
        rst_n_i = 1'b1;
        tick();
    endtask

    task automatic test_frame();
        send_hdr(DT_FS, 16'd0);
        checks++;
        if ({frame_start_o, frame_active_o, line_count_o} !== {1'b1, 1'b1, 16'd0}) begin
            failures++;
            $display("FAIL frame_fs: got fs=%b fa=%b cnt=%0d exp 1 1 0", frame_start_o, frame_active_o, line_count_o);
        end
        tick();
        checks++;
        if (frame_start_o !== 1'b0) begin
            failures++;
            $display("FAIL frame_fs_pulse: got %b exp 0", frame_start_o);
        end
        for (int ln = 1; ln <= 2; ln++) begin
            send_hdr(DT_RAW, 16'd40);
            base_cnt = dv_cnt;
            base_sum = dsum;
            send_beats(10);
            checks++;
            if ({depack_valid_o, depack_data_o, line_active_o, line_done_o} !== {1'b1, 32'h0A0A_0A0A, 1'b1, 1'b0}) begin
                failures++;
                $display("FAIL frame_last_beat: got dv=%b data=%h la=%b ld=%b", depack_valid_o, depack_data_o,
                         line_active_o, line_done_o);
            end
            tick();
            checks++;
            if ({depack_valid_o, depack_data_o, line_done_o, line_count_o} !== {1'b1, 32'h0, 1'b1, 16'(ln)}) begin
                failures++;
                $display("FAIL frame_flush: got dv=%b data=%h ld=%b cnt=%0d exp cnt=%0d", depack_valid_o,
                         depack_data_o, line_done_o, line_count_o, ln);
            end
            tick();
            checks++;
            if ({depack_valid_o, line_active_o, line_done_o} !== 3'b000) begin
                failures++;
                $display("FAIL frame_after_flush: got dv=%b la=%b ld=%b exp 000", depack_valid_o, line_active_o,
                         line_done_o);
            end
            checks++;
            if ((dv_cnt - base_cnt) != 11 || (dsum - base_sum) !== 32'h3737_3737) begin
                failures++;
                $display("FAIL frame_beats: got n=%0d sum=%h exp 11 37373737", dv_cnt - base_cnt, dsum - base_sum);
            end
        end
        send_hdr(DT_FE, 16'd0);
        checks++;
        if ({frame_end_o, frame_active_o, line_count_o} !== {1'b1, 1'b0, 16'd2}) begin
            failures++;
            $display("FAIL frame_fe: got fe=%b fa=%b cnt=%0d exp 1 0 2", frame_end_o, frame_active_o, line_count_o);
        end
        checks++;
        if ({err_wc_o, err_gap_o, err_trunc_o} !== 3'b000) begin
            failures++;
            $display("FAIL frame_no_err: got %b%b%b exp 000", err_wc_o, err_gap_o, err_trunc_o);
        end
        tick();
        checks++;
        if (frame_end_o !== 1'b0) begin
            failures++;
            $display("FAIL frame_fe_pulse: got %b exp 0", frame_end_o);
        end
    endtask

    task automatic test_wc_err();
        send_hdr(DT_FS, 16'd0);
        send_hdr(DT_RAW, 16'd42);
        checks++;
        if ({err_wc_o, depack_valid_o} !== 2'b10) begin
            failures++;
            $display("FAIL wc_err_set: got err=%b dv=%b exp 1 0", err_wc_o, depack_valid_o);
        end
        base_cnt = dv_cnt;
        base_sum = dsum;
        send_beats(11);
        tick();
        checks++;
        if ({line_done_o, depack_data_o, line_count_o} !== {1'b1, 32'h0, 16'd1}) begin
            failures++;
            $display("FAIL wc_err_flush: got ld=%b data=%h cnt=%0d exp 1 0 1", line_done_o, depack_data_o, line_count_o);
        end
        tick();
        checks++;
        if ((dv_cnt - base_cnt) != 12 || (dsum - base_sum) !== 32'h4242_4242) begin
            failures++;
            $display("FAIL wc_err_beats: got n=%0d sum=%h exp 12 42424242", dv_cnt - base_cnt, dsum - base_sum);
        end
    endtask

    task automatic test_gap();
        clear_err_i = 1'b1;
        tick();
        clear_err_i = 1'b0;
        checks++;
        if ({err_wc_o, err_gap_o, err_trunc_o} !== 3'b000) begin
            failures++;
            $display("FAIL gap_clear: got %b%b%b exp 000", err_wc_o, err_gap_o, err_trunc_o);
        end
        send_hdr(DT_RAW, 16'd40);
        send_beats(4);
        tick();
        checks++;
        if ({err_gap_o, depack_valid_o, line_active_o} !== 3'b100) begin
            failures++;
            $display("FAIL gap_detect: got err=%b dv=%b la=%b exp 1 0 0", err_gap_o, depack_valid_o, line_active_o);
        end
        base_cnt = dv_cnt;
        send_beats(2);
        tick();
        checks++;
        if ((dv_cnt - base_cnt) != 0 || line_done_o !== 1'b0 || line_count_o !== 16'd1) begin
            failures++;
            $display("FAIL gap_frame_state: got n=%0d ld=%b cnt=%0d exp 0 0 1", dv_cnt - base_cnt, line_done_o, line_count_o);
        end
        checks++;
        if ({err_wc_o, err_gap_o, err_trunc_o} !== 3'b010) begin
            failures++;
            $display("FAIL gap_flags: got %b%b%b exp 010", err_wc_o, err_gap_o, err_trunc_o);
        end
    endtask

    task automatic test_trunc();
        clear_err_i = 1'b1;
        tick();
        clear_err_i = 1'b0;
        send_hdr(DT_RAW, 16'd40);
        send_beats(2);
        pkt_hdr_valid_i = 1'b1;
        pkt_dt_i        = DT_RAW;
        pkt_wc_i        = 16'd8;
        payload_valid_i = 1'b1;
        payload_i       = 32'hDEAD_BEEF;
        tick();
        pkt_hdr_valid_i = 1'b0;
        payload_valid_i = 1'b0;
        checks++;
        if ({err_trunc_o, err_gap_o, depack_valid_o} !== 3'b100) begin
            failures++;
            $display("FAIL trunc_detect: got tr=%b gap=%b dv=%b exp 1 0 0", err_trunc_o, err_gap_o, depack_valid_o);
        end
        send_beats(2);
        checks++;
        if ({depack_valid_o, depack_data_o} !== {1'b1, 32'h0202_0202}) begin
            failures++;
            $display("FAIL trunc_new_line: got dv=%b data=%h exp 1 02020202", depack_valid_o, depack_data_o);
        end
        tick();
        checks++;
        if ({line_done_o, line_count_o} !== {1'b1, 16'd2}) begin
            failures++;
            $display("FAIL trunc_flush: got ld=%b cnt=%0d exp 1 2", line_done_o, line_count_o);
        end
        // Clear and a fresh wc error in the same cycle: the set must win.
        clear_err_i     = 1'b1;
        pkt_hdr_valid_i = 1'b1;
        pkt_dt_i        = DT_RAW;
        pkt_wc_i        = 16'd7;
        tick();
        clear_err_i     = 1'b0;
        pkt_hdr_valid_i = 1'b0;
        checks++;
        if ({err_wc_o, err_gap_o, err_trunc_o} !== 3'b100) begin
            failures++;
            $display("FAIL trunc_set_wins: got %b%b%b exp 100", err_wc_o, err_gap_o, err_trunc_o);
        end
        send_beats(2);
        tick();
        checks++;
        if ({line_done_o, line_count_o} !== {1'b1, 16'd3}) begin
            failures++;
            $display("FAIL trunc_wc7_line: got ld=%b cnt=%0d exp 1 3", line_done_o, line_count_o);
        end
        clear_err_i = 1'b1;
        tick();
        clear_err_i = 1'b0;
        checks++;
        if ({err_wc_o, err_gap_o, err_trunc_o} !== 3'b000) begin
            failures++;
            $display("FAIL trunc_clear: got %b%b%b exp 000", err_wc_o, err_gap_o, err_trunc_o);
        end
    endtask

    task automatic test_ignore();
        base_cnt = dv_cnt;
        send_hdr(6'h12, 16'd40);
        send_beats(3);
        tick();
        checks++;
        if ((dv_cnt - base_cnt) != 0 || frame_start_o !== 1'b0 || {err_wc_o, err_gap_o, err_trunc_o} !== 3'b000) begin
            failures++;
            $display("FAIL ignore_frame: got n=%0d fs=%b err=%b%b%b exp 0 0 000", dv_cnt - base_cnt, frame_start_o,
                     err_wc_o, err_gap_o, err_trunc_o);
        end
        send_hdr(DT_FE, 16'd0);
        send_beats(2);
        send_hdr(DT_RAW, 16'd40);
        send_beats(3);
        tick();
        checks++;
        if ((dv_cnt - base_cnt) != 0 || frame_active_o !== 1'b0 || line_active_o !== 1'b0 ||
            {err_wc_o, err_gap_o, err_trunc_o} !== 3'b000) begin
            failures++;
            $display("FAIL ignore_idle: got n=%0d fa=%b la=%b err=%b%b%b exp 0 0 0 000", dv_cnt - base_cnt,
                     frame_active_o, line_active_o, err_wc_o, err_gap_o, err_trunc_o);
        end
    endtask

    task automatic test_skid_reset();
        send_hdr(DT_FS, 16'd0);
        send_hdr(DT_RAW, 16'd8);
        send_beats(2);
        send_hdr(DT_FS, 16'd0);
        checks++;
        if ({depack_valid_o, depack_data_o, line_done_o, frame_start_o, line_count_o} !==
            {1'b1, 32'h0, 1'b1, 1'b0, 16'd1}) begin
            failures++;
            $display("FAIL skid_flush: got dv=%b data=%h ld=%b fs=%b cnt=%0d exp 1 0 1 0 1", depack_valid_o,
                     depack_data_o, line_done_o, frame_start_o, line_count_o);
        end
        tick();
        checks++;
        if ({frame_start_o, line_count_o, depack_valid_o, frame_active_o} !== {1'b1, 16'd0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL skid_fs: got fs=%b cnt=%0d dv=%b fa=%b exp 1 0 0 1", frame_start_o, line_count_o,
                     depack_valid_o, frame_active_o);
        end
        tick();
        checks++;
        if (frame_start_o !== 1'b0) begin
            failures++;
            $display("FAIL skid_fs_pulse: got %b exp 0", frame_start_o);
        end
        send_hdr(DT_RAW, 16'd40);
        send_beats(3);
        rst_n_i         = 1'b0;
        payload_valid_i = 1'b1;
        payload_i       = 32'h1234_5678;
        tick();
        payload_valid_i = 1'b0;
        checks++;
        if ({depack_valid_o, depack_data_o, frame_active_o, line_active_o, frame_start_o, frame_end_o,
             line_done_o, line_count_o, err_wc_o, err_gap_o, err_trunc_o} !== 57'd0) begin
            failures++;
            $display("FAIL reset_midline: got dv=%b data=%h fa=%b la=%b ld=%b", depack_valid_o, depack_data_o,
                     frame_active_o, line_active_o, line_done_o);
        end
        rst_n_i = 1'b1;
        tick();
        base_cnt = dv_cnt;
        send_hdr(DT_RAW, 16'd8);
        send_beats(2);
        tick();
        checks++;
        if ((dv_cnt - base_cnt) != 0 || line_done_o !== 1'b0 || frame_active_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle: got n=%0d ld=%b fa=%b exp 0 0 0", dv_cnt - base_cnt, line_done_o, frame_active_o);
        end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_wc_err();
        test_gap();
        test_trunc();
        test_ignore();
        test_skid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
